// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming [7,4] types, constants and encode function
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CW_W   = 7;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CW_W-1:0]   codeword_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_t;

    // Layout {d3,d2,d1,p4,d0,p2,p1} matches what hamming_decoder consumes
    function automatic codeword_t hamming_encode(input data_t d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

endpackage

// File: rtl/hamming_encoder.sv
// rtl/hamming_encoder.sv - combinational wrapper around hamming_encode
module hamming_encoder
    import hamming_pkg::*;
(
    input  data_t     data,
    output codeword_t cw
);

    assign cw = hamming_encode(data);

endmodule

// File: rtl/hamming_tx.sv
// rtl/hamming_tx.sv - streaming Hamming [7,4] transmitter, LSB-first serializer
// Optional HAMMING_ERR_INJECT_EN adds err_pos/err_en single-bit fault injection.
module hamming_tx
    import hamming_pkg::*;
#(
    parameter int unsigned BIT_DIV = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [2:0]        err_pos,
    input  logic              err_en,
`endif
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_start,
    output logic              frame_done,
    output logic              busy
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BIT_DIV - 1);
    localparam logic [2:0]       LAST_BIT = 3'(CW_W - 1);

    tx_state_t        state, state_d;
    codeword_t        hold, hold_d;
    logic             hold_full, hold_full_d;
    codeword_t        shift, shift_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt, div_cnt_d;

    codeword_t enc_cw;
    codeword_t flip;
    codeword_t cw_in;
    logic      accept;

    hamming_encoder u_enc (
        .data (in_data),
        .cw   (enc_cw)
    );

`ifdef HAMMING_ERR_INJECT_EN
    // err_pos counts codeword positions from 1; 0 leaves the codeword clean
    always_comb begin
        flip = '0;
        for (int i = 0; i < CW_W; i++) begin
            flip[i] = err_en && (err_pos == 3'(i + 1));
        end
    end
`else
    assign flip = '0;
`endif

    assign cw_in    = enc_cw ^ flip;
    assign in_ready = ~hold_full;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == SHIFT) || hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            hold_full <= hold_full_d;
            shift     <= shift_d;
            bit_cnt   <= bit_cnt_d;
            div_cnt   <= div_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        hold_d      = hold;
        hold_full_d = hold_full;
        shift_d     = shift;
        bit_cnt_d   = bit_cnt;
        div_cnt_d   = div_cnt;
        tx_bit      = 1'b0;
        tx_valid    = 1'b0;
        tx_start    = 1'b0;
        frame_done  = 1'b0;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    shift_d     = hold;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    div_cnt_d   = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                tx_bit   = shift[0];
                tx_valid = 1'b1;
                tx_start = (bit_cnt == 3'd0);
                if (div_cnt == DIV_MAX) begin
                    div_cnt_d = '0;
                    if (bit_cnt == LAST_BIT) begin
                        frame_done = 1'b1;
                        // A waiting codeword is reloaded on the same edge so frames abut
                        if (hold_full) begin
                            shift_d     = hold;
                            hold_full_d = 1'b0;
                            bit_cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d   = {1'b0, shift[CW_W-1:1]};
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // accept never coincides with a load: in_ready is low while hold_full
        if (accept) begin
            hold_d      = cw_in;
            hold_full_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_tx.sv
// tb/tb_hamming_tx.sv - scoreboard bench for hamming_tx at BIT_DIV 1, 4 and 2
module tb_hamming_tx;

    typedef struct {
        logic [6:0] cw;
        bit         bad;
        int         gap;
        int         start;
    } frame_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_data    [3];
    logic       in_valid   [3];
    logic       in_ready   [3];
    logic       tx_bit     [3];
    logic       tx_valid   [3];
    logic       tx_start   [3];
    logic       frame_done [3];
    logic       busy       [3];
`ifdef HAMMING_ERR_INJECT_EN
    logic [2:0] err_pos    [3];
    logic       err_en     [3];
`endif

    int vectors;
    int miscompares;
    int cyc;
    int sel;
    int mon_cnt;
    int idle_cnt;
    int aborted;
    int stray;
    int short_frames;
    frame_t     cur;
    frame_t     rx_q  [$];
    logic [6:0] exp_q [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hamming_tx #(.BIT_DIV(g == 0 ? 1 : (g == 1 ? 4 : 2))) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_data    (in_data[g]),
            .in_valid   (in_valid[g]),
`ifdef HAMMING_ERR_INJECT_EN
            .err_pos    (err_pos[g]),
            .err_en     (err_en[g]),
`endif
            .in_ready   (in_ready[g]),
            .tx_bit     (tx_bit[g]),
            .tx_valid   (tx_valid[g]),
            .tx_start   (tx_start[g]),
            .frame_done (frame_done[g]),
            .busy       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 4 : 2);
    endfunction

    // Reference built from the parity-check view: parity at position p covers positions j with j&p
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        logic [6:0] c;
        c = '0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        for (int p = 1; p <= 4; p = p * 2) begin
            for (int j = 1; j <= 7; j++) begin
                if (((j & p) != 0) && (j != p)) c[p-1] = c[p-1] ^ c[j-1];
            end
        end
        return c;
    endfunction

    function automatic int ref_syndrome(input logic [6:0] c);
        int s;
        s = 0;
        for (int j = 1; j <= 7; j++) begin
            if (c[j-1]) s = s ^ j;
        end
        return s;
    endfunction

    // Reassembles frames of the selected instance and flags any framing irregularity
    always @(negedge clk) begin
        int div;
        int pos;
        if (!rst_n) begin
            if (mon_cnt != 0) aborted++;
            mon_cnt  = 0;
            idle_cnt = 0;
        end else if (tx_valid[sel]) begin
            div = div_of(sel);
            if (mon_cnt == 0) begin
                cur.cw    = '0;
                cur.bad   = 1'b0;
                cur.gap   = idle_cnt;
                cur.start = cyc;
            end
            pos = mon_cnt / div;
            if (mon_cnt % div == 0) cur.cw[pos] = tx_bit[sel];
            else if (tx_bit[sel] !== cur.cw[pos]) cur.bad = 1'b1;
            if (tx_start[sel] !== (pos == 0)) cur.bad = 1'b1;
            if (frame_done[sel] !== (mon_cnt == 7 * div - 1)) cur.bad = 1'b1;
            if (busy[sel] !== 1'b1) cur.bad = 1'b1;
            mon_cnt++;
            if (mon_cnt == 7 * div) begin
                rx_q.push_back(cur);
                mon_cnt = 0;
            end
            idle_cnt = 0;
        end else begin
            if (mon_cnt != 0) begin
                short_frames++;
                mon_cnt = 0;
            end
            if (tx_bit[sel] || tx_start[sel] || frame_done[sel]) stray++;
            idle_cnt++;
        end
    end

    task automatic send(input int idx, input logic [3:0] d, output int acc);
        logic [6:0] e;
        int n;
        @(negedge clk);
        in_data[idx]  = d;
        in_valid[idx] = 1'b1;
        n = 0;
        while (!in_ready[idx] && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL send_ready[%0d]: in_ready stuck low, got 0 want 1", idx);
        end else begin
            e = ref_enc(d);
`ifdef HAMMING_ERR_INJECT_EN
            if (err_en[idx] && err_pos[idx] != 0) e[err_pos[idx]-1] = ~e[err_pos[idx]-1];
`endif
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            acc = cyc;
        end
    endtask

    task automatic drop_valid(input int idx);
        @(negedge clk);
        in_valid[idx] = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (rx_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_frames: got %0d frames want %0d", rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        for (int i = 0; i < 3; i++) begin
            obs = {in_ready[i], tx_bit[i], tx_valid[i], tx_start[i], frame_done[i], busy[i]};
            vectors++;
            if (obs !== 6'b100000) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got %b want %b", i, obs, 6'b100000);
            end
        end
    endtask

    task automatic test_single_div1();
        frame_t f;
        logic [6:0] e;
        int acc;
        sel = 0;
        send(0, 4'b1011, acc);
        drop_valid(0);
        wait_frames(1, 60);
        if (rx_q.size() == 0) return;
        f = rx_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (f.cw !== 7'b1010101) begin
            miscompares++;
            $display("FAIL div1_cw_example: got %b want %b", f.cw, 7'b1010101);
        end
        vectors++;
        if (f.cw !== e) begin
            miscompares++;
            $display("FAIL div1_cw_model: got %b want %b", f.cw, e);
        end
        vectors++;
        if (f.bad !== 1'b0) begin
            miscompares++;
            $display("FAIL div1_framing: got bad=%0d want 0", f.bad);
        end
        vectors++;
        if (f.start - acc !== 1) begin
            miscompares++;
            $display("FAIL div1_latency: got %0d want 1", f.start - acc);
        end
    endtask

    task automatic test_div4();
        frame_t f;
        logic [6:0] e;
        int acc;
        sel = 1;
        send(1, 4'b0001, acc);
        drop_valid(1);
        wait_frames(1, 120);
        if (rx_q.size() == 0) return;
        f = rx_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (f.cw !== 7'b0000111 || f.cw !== e) begin
            miscompares++;
            $display("FAIL div4_cw: got %b want %b", f.cw, e);
        end
        vectors++;
        if (f.bad !== 1'b0 || short_frames !== 0) begin
            miscompares++;
            $display("FAIL div4_framing: got bad=%0d short=%0d want 0 0", f.bad, short_frames);
        end
    endtask

    task automatic test_back_to_back();
        frame_t f [3];
        logic [6:0] e [3];
        int acc [3];
        sel = 0;
        send(0, 4'b0000, acc[0]);
        send(0, 4'b1111, acc[1]);
        send(0, 4'b0101, acc[2]);
        drop_valid(0);
        wait_frames(3, 100);
        if (rx_q.size() < 3) return;
        for (int i = 0; i < 3; i++) begin
            f[i] = rx_q.pop_front();
            e[i] = exp_q.pop_front();
            vectors++;
            if (f[i].cw !== e[i] || f[i].bad !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_frame[%0d]: got %b bad=%0d want %b bad=0", i, f[i].cw, f[i].bad, e[i]);
            end
        end
        vectors++;
        if (f[0].cw !== 7'h00 || f[1].cw !== 7'h7F) begin
            miscompares++;
            $display("FAIL b2b_values: got %h %h want 00 7f", f[0].cw, f[1].cw);
        end
        vectors++;
        if (f[1].gap !== 0 || f[2].gap !== 0) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d %0d want 0 0", f[1].gap, f[2].gap);
        end
        vectors++;
        if (acc[1] !== f[0].start + 1) begin
            miscompares++;
            $display("FAIL b2b_second_accept: got cycle %0d want %0d", acc[1], f[0].start + 1);
        end
        vectors++;
        if (acc[2] !== f[1].start + 1) begin
            miscompares++;
            $display("FAIL b2b_third_accept: got cycle %0d want %0d", acc[2], f[1].start + 1);
        end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        logic [6:0] e;
        logic [5:0] obs;
        int acc;
        int k;
        int ab0;
        sel = 2;
        send(2, 4'b1011, acc);
        drop_valid(2);
        k = 0;
        while (mon_cnt != 7 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        vectors++;
        if (mon_cnt != 7) begin
            miscompares++;
            $display("FAIL rstmid_reach_bit3: got count %0d want 7", mon_cnt);
        end
        ab0 = aborted;
        rst_n = 1'b0;
        #1;
        obs = {in_ready[2], tx_bit[2], tx_valid[2], tx_start[2], frame_done[2], busy[2]};
        vectors++;
        if (obs !== 6'b100000) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got %b want %b", obs, 6'b100000);
        end
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        obs = {in_ready[2], tx_bit[2], tx_valid[2], tx_start[2], frame_done[2], busy[2]};
        vectors++;
        if (obs !== 6'b100000 || aborted !== ab0 + 1 || rx_q.size() !== 0) begin
            miscompares++;
            $display("FAIL rstmid_abort: got %b aborted=%0d frames=%0d want 100000 %0d 0",
                     obs, aborted - ab0, rx_q.size(), 1);
        end
        rst_n = 1'b1;
        exp_q.delete();
        send(2, 4'b1011, acc);
        drop_valid(2);
        wait_frames(1, 60);
        if (rx_q.size() == 0) return;
        f = rx_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (f.cw !== 7'b1010101 || f.cw !== e || f.bad !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_after: got %b bad=%0d want %b bad=0", f.cw, f.bad, e);
        end
    endtask

    task automatic test_all_nibbles();
        frame_t f;
        logic [6:0] e;
        logic [3:0] d;
        int acc;
        sel = 0;
        for (int n = 0; n < 16; n++) send(0, 4'(n), acc);
        drop_valid(0);
        wait_frames(16, 300);
        if (rx_q.size() < 16) return;
        for (int n = 0; n < 16; n++) begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            d = {f.cw[6], f.cw[5], f.cw[4], f.cw[2]};
            vectors++;
            if (f.cw !== e || f.bad !== 1'b0 || ref_syndrome(f.cw) != 0 || d !== 4'(n)) begin
                miscompares++;
                $display("FAIL nibble_%0d: got cw %b syn %0d data %h want cw %b syn 0 data %h",
                         n, f.cw, ref_syndrome(f.cw), d, e, 4'(n));
            end
        end
    endtask

`ifdef HAMMING_ERR_INJECT_EN
    task automatic test_err_inject();
        frame_t f;
        logic [6:0] e;
        logic [6:0] c;
        int s;
        int acc;
        sel = 0;
        err_en[0]  = 1'b1;
        err_pos[0] = 3'd5;
        send(0, 4'b1011, acc);
        drop_valid(0);
        err_en[0]  = 1'b0;
        err_pos[0] = 3'd0;
        wait_frames(1, 60);
        if (rx_q.size() == 0) return;
        f = rx_q.pop_front();
        e = exp_q.pop_front();
        s = ref_syndrome(f.cw);
        c = f.cw;
        if (s != 0) c[s-1] = ~c[s-1];
        vectors++;
        if (f.cw !== 7'b1000101 || f.cw !== e) begin
            miscompares++;
            $display("FAIL errinj_cw: got %b want %b", f.cw, 7'b1000101);
        end
        vectors++;
        if (s != 5 || {c[6], c[5], c[4], c[2]} !== 4'b1011) begin
            miscompares++;
            $display("FAIL errinj_decode: got syn %0d data %b want syn 5 data 1011",
                     s, {c[6], c[5], c[4], c[2]});
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        sel          = 0;
        mon_cnt      = 0;
        idle_cnt     = 0;
        aborted      = 0;
        stray        = 0;
        short_frames = 0;
        for (int i = 0; i < 3; i++) begin
            in_data[i]  = '0;
            in_valid[i] = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
            err_pos[i]  = '0;
            err_en[i]   = 1'b0;
`endif
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_div1();
        test_div4();
        test_back_to_back();
        test_reset_mid();
        test_all_nibbles();
`ifdef HAMMING_ERR_INJECT_EN
        test_err_inject();
`endif
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (stray !== 0 || short_frames !== 0) begin
            miscompares++;
            $display("FAIL idle_outputs: got stray=%0d short=%0d want 0 0", stray, short_frames);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hamming_tx.md
Name: hamming_tx

Overview:
- Streaming Hamming [7,4] transmitter, the sending end of the link whose receive side is hamming_decoder.
- Accepts 4-bit data nibbles over a valid/ready handshake and encodes each into a 7-bit codeword.
- Buffers one codeword and serializes it LSB-first onto a 1-bit line with framing strobes.
- Codeword bit layout is identical to the one hamming_decoder consumes.

Parameters:
- BIT_DIV, 1, clock cycles per serial bit (legal range 1..256).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  4  data nibble {d3,d2,d1,d0}
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a nibble this cycle
- tx_bit  out  1  serial codeword bit
- tx_valid  out  1  tx_bit carries a codeword bit
- tx_start  out  1  high during the bit period of codeword bit 0
- frame_done  out  1  1-cycle pulse on the last clock of bit 6
- busy  out  1  shift register or holding register occupied

Behaviour:
- Codeword cw[6:0] = {d3,d2,d1,p4,d0,p2,p1}.
  - p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3.
  - Example: 4'b1011 -> 7'b1010101.
- Reset (async assert, sync release): all outputs 0 except in_ready = 1; holding register, shift register and counters cleared. Reset mid-frame aborts the frame; no frame_done is generated.
- Holding register (1 entry):
  - in_ready = !hold_full, registered.
  - An edge with in_valid && in_ready stores the encoded codeword and sets hold_full.
  - in_data is ignored when in_ready = 0.
- FSM states:
  - IDLE: tx_valid = 0, tx_bit = 0. If hold_full, the next edge moves the holding register into the shift register, clears hold_full, resets bit_cnt and div_cnt, and goes to SHIFT.
  - SHIFT: tx_bit = shift[0]; tx_valid = 1; tx_start = 1 while bit_cnt == 0. div_cnt counts 0..BIT_DIV-1. On wrap, the shift register shifts right and bit_cnt increments.
  - End of frame (bit_cnt == 6 and div_cnt == BIT_DIV-1): frame_done pulses.
    - If hold_full on that same edge: reload directly, stay in SHIFT, tx_valid stays high with no gap, tx_start rises for the new frame.
    - Otherwise return to IDLE.
  - The holding register load and the reload are the same edge. hold_full clears and in_ready rises one cycle later; a simultaneous new accept is therefore impossible.
- Latency: accept at edge k -> tx_valid = 1, tx_start = 1, tx_bit = cw[0] after edge k+1.
- Frame length: exactly 7*BIT_DIV cycles of tx_valid.
- BIT_DIV = 1: one bit per clock; back-to-back frames sustain 7 cycles per codeword. div_cnt width is max(1, $clog2(BIT_DIV)).
- busy = (state == SHIFT) || hold_full.

Optional Feature:
- Macro: HAMMING_ERR_INJECT_EN.
- With the macro defined:
  - Adds ports err_pos in 3 and err_en in 1, both sampled at the accept edge.
  - If err_en = 1 and err_pos is in 1..7, codeword bit (err_pos-1) is inverted before storage.
  - err_pos = 0 means no flip.
  - Used to exercise decoder correction.
- Without the macro: the ports are absent and the codeword is always clean.

Decomposition:
- hamming_pkg holds:
  - DATA_W = 4, CW_W = 7
  - typedefs data_t [3:0], codeword_t [6:0]
  - typedef enum tx_state_t {IDLE, SHIFT}
  - function hamming_encode(data_t) -> codeword_t, shared with the decoder's checking model
- One natural sub-module: hamming_encoder, a combinational wrapper of hamming_encode that hamming_tx instantiates.

Test Plan:
- BIT_DIV = 1, send 4'b1011 -> tx_bit sequence 1,0,1,0,1,0,1 over 7 cycles.
  - tx_start only on cycle 1; frame_done on cycle 7; tx_valid exactly 7 cycles.
- BIT_DIV = 4, send 4'b0001 -> each bit held 4 cycles: 1,1,1,0,0,0,0 (cw = 7'b0000111); 28 tx_valid cycles.
- Back-to-back 4'b0000, 4'b1111 with in_valid held high:
  - Second nibble accepted during frame 1.
  - Frames 0x00 then 0x7F with no tx_valid gap.
  - in_ready low while hold_full.
  - Third nibble is not accepted until the reload edge + 1.
- Assert rst_n mid-frame (bit 3, BIT_DIV = 2):
  - Outputs go 0 immediately, in_ready = 1, no frame_done.
  - After release, 4'b1011 transmits cleanly.
- Every nibble 0..15 through the encoder, serial stream reassembled and fed to hamming_decoder -> syndrome 0 and data equal to input for all 16.
- With HAMMING_ERR_INJECT_EN, err_en = 1 and err_pos = 5 on 4'b1011 -> cw 7'b1000101 transmitted; decoder syndrome 5 and corrected data 4'b1011.
